// File: rtl/refresh_timer.sv
// refresh_timer: tREFI down-counter feeding a saturating owed-refresh counter with req/ack handoff.
// Optional early refresh pull-in while the scheduler is idle is enabled by defining REF_PULLIN_EN.
module refresh_timer #(
  parameter int TREFI    = 7800,
  parameter int CNT_W    = 16,
  parameter int MAX_PEND = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ref_ack,
`ifdef REF_PULLIN_EN
  input  logic             ref_idle,
`endif
  output logic             ref_req,
  output logic [3:0]       pending,
  output logic             urgent,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       pend_q, pend_d;
  logic             ovf_q, ovf_d, pull_q, pull_d;
  logic             tick, acc, full, reload;
  always_comb begin
    full    = pend_q == 4'(MAX_PEND);
    tick    = en && count_q == '0;
    acc     = ref_ack && ref_req;
    // an ack with nothing owed can only be a pulled-in refresh, which restarts the interval
    reload  = tick || (acc && pend_q == 4'd0);
    count_d = reload ? CNT_W'(TREFI - 1) : count_q - CNT_W'(en);
    pend_d  = (tick && !acc) ? pend_q + 4'(!full) :
              (acc && !tick && pend_q != 4'd0) ? pend_q - 4'd1 : pend_q;
    ovf_d   = ovf_q || (tick && !acc && full);
`ifdef REF_PULLIN_EN
    pull_d  = ref_idle && !acc && (pull_q || (pend_q == 4'd0 && count_q < CNT_W'(TREFI / 2)));
`else
    pull_d  = 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_W'(TREFI - 1);
      pend_q  <= 4'd0;
      ovf_q   <= 1'b0;
      pull_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pull_q  <= pull_d;
    end
  end
  assign ref_req = pend_q != 4'd0 || pull_q;
  assign urgent  = full;
  assign pending = pend_q;
  assign ovf     = ovf_q;
  assign count   = count_q;
endmodule
